// File: rtl/g729_fifo_pkg.sv
// Shared constants and output-stage encodings for the G729 FIFO controller.
package g729_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Cycles between ram_rd_en and valid ram_rd_data on the external RAM.
    localparam int RAM_RD_LATENCY = 1;

    // FWFT output stage occupancy.
    typedef enum logic [1:0] {
        OS_EMPTY = 2'd0,
        OS_ONE   = 2'd1,
        OS_TWO   = 2'd2
    } os_state_t;

    // Number of words held by an output-stage state.
    function automatic logic [1:0] os_level(input os_state_t s);
        logic [1:0] lvl;
        case (s)
            OS_ONE:  lvl = 2'd1;
            OS_TWO:  lvl = 2'd2;
            default: lvl = 2'd0;
        endcase
        return lvl;
    endfunction

    // Output-stage state for a given number of held words.
    function automatic os_state_t os_from_level(input logic [1:0] lvl);
        os_state_t s;
        case (lvl)
            2'd1:    s = OS_ONE;
            2'd2:    s = OS_TWO;
            default: s = OS_EMPTY;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo_ctrl_out_stage.sv
// Two-entry first-word-fall-through staging buffer. Prefetches words from
// the 1-cycle RAM so the head word is always presented from a register and
// back-to-back pops run without bubbles.
module fifo_out_stage
    import g729_fifo_pkg::*;
#(
    parameter int RAM_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      ram_avail,
    input  logic                      rd_en,
    input  logic [RAM_DATA_WIDTH-1:0] ram_rd_data,
    output logic                      fetch,
    output logic                      pop_acc,
    output logic                      rd_valid,
    output logic [RAM_DATA_WIDTH-1:0] rd_data
);

    os_state_t                 state_reg;
    logic                      inflight_reg;
    logic [RAM_DATA_WIDTH-1:0] head_reg;
    logic [RAM_DATA_WIDTH-1:0] tail_reg;
    logic [1:0]                level;
    logic [1:0]                level_next;

    assign level    = os_level(state_reg);
    assign rd_valid = (state_reg != OS_EMPTY);
    assign rd_data  = head_reg;
    assign pop_acc  = rd_en & rd_valid & ~flush & ~rst;

    // Staged words after this edge: an in-flight word lands, a pop leaves.
    // A pop implies level >= 1 and level + inflight never exceeds 2.
    assign level_next = level + {1'b0, inflight_reg} - {1'b0, pop_acc};

    // Prefetch only while the post-edge stage still has room for the word.
    assign fetch = ram_avail & ~flush & ~rst & (level_next < 2'd2);

    // Stage state machine, in-flight tracking and head/tail data movement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= OS_EMPTY;
            inflight_reg <= 1'b0;
            head_reg     <= '0;
            tail_reg     <= '0;
        end else if (flush) begin
            state_reg    <= OS_EMPTY;
            inflight_reg <= 1'b0;
            head_reg     <= '0;
            tail_reg     <= '0;
        end else begin
            inflight_reg <= fetch;
            state_reg    <= os_from_level(level_next);
            case ({inflight_reg, pop_acc})
                2'b11: begin
                    if (state_reg == OS_TWO) begin
                        head_reg <= tail_reg;
                        tail_reg <= ram_rd_data;
                    end else begin
                        head_reg <= ram_rd_data;
                    end
                end
                2'b01: head_reg <= tail_reg;
                2'b10: begin
                    if (state_reg == OS_EMPTY) begin
                        head_reg <= ram_rd_data;
                    end else begin
                        tail_reg <= ram_rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller driving an external 1-cycle simple-dual-port
// RAM. Standard or first-word-fall-through read side, exact occupancy count,
// programmable almost flags, sticky error flags and synchronous flush.
module sync_fifo_ctrl
    import g729_fifo_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 10,
    parameter int RAM_DATA_WIDTH = 32,
    parameter int FWFT           = 0,
    parameter int AFULL_THRESH   = (2 ** RAM_ADDR_WIDTH) - 4,
    parameter int AEMPTY_THRESH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      wr_en,
    input  logic [RAM_DATA_WIDTH-1:0] wr_data,
    input  logic                      rd_en,
    output logic [RAM_DATA_WIDTH-1:0] rd_data,
    output logic                      rd_valid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [RAM_ADDR_WIDTH+1:0] count,
    output logic                      overflow,
    output logic                      underflow,
    output logic [RAM_ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [RAM_DATA_WIDTH-1:0] ram_wr_data,
    output logic                      ram_wr_en,
    output logic [RAM_ADDR_WIDTH-1:0] ram_rd_addr,
    output logic                      ram_rd_en,
    input  logic [RAM_DATA_WIDTH-1:0] ram_rd_data
);

    localparam int AW    = RAM_ADDR_WIDTH;
    localparam int PW    = AW + 1;
    localparam int CW    = AW + 2;
    localparam int DEPTH = 2 ** AW;

    localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] ram_occ;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          overflow_reg;
    logic          underflow_reg;
    logic          full_w;
    logic          empty_w;
    logic          push_acc;
    logic          pop_acc;
    logic          fetch;

    // Wrap bit keeps the subtraction exact over the full 0..DEPTH range.
    assign ram_occ  = wr_ptr_reg - rd_ptr_reg;
    assign full_w   = (ram_occ == DEPTH_P);
    assign push_acc = wr_en & ~full_w & ~flush & ~rst;

    assign ram_wr_en   = push_acc;
    assign ram_wr_addr = wr_ptr_reg[AW-1:0];
    assign ram_wr_data = wr_data;
    assign ram_rd_en   = fetch;
    assign ram_rd_addr = rd_ptr_reg[AW-1:0];

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Words are prefetched into a register stage ahead of the pop.
            fifo_out_stage #(
                .RAM_DATA_WIDTH (RAM_DATA_WIDTH)
            ) u_out_stage (
                .clk         (clk),
                .rst         (rst),
                .flush       (flush),
                .ram_avail   (ram_occ != '0),
                .rd_en       (rd_en),
                .ram_rd_data (ram_rd_data),
                .fetch       (fetch),
                .pop_acc     (pop_acc),
                .rd_valid    (rd_valid),
                .rd_data     (rd_data)
            );
            assign empty_w = ~rd_valid;
        end else begin : g_std
            logic                      rd_valid_reg;
            logic [RAM_DATA_WIDTH-1:0] rd_hold_reg;

            assign empty_w  = (ram_occ == '0);
            assign pop_acc  = rd_en & ~empty_w & ~flush & ~rst;
            assign fetch    = pop_acc;
            assign rd_valid = rd_valid_reg;
            // RAM output is passed straight through in the valid cycle and
            // held afterwards so rd_data stays stable between pops.
            assign rd_data  = rd_valid_reg ? ram_rd_data : rd_hold_reg;

            // Read-valid pipeline and hold register for the last popped word.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_valid_reg <= 1'b0;
                    rd_hold_reg  <= '0;
                end else if (flush) begin
                    rd_valid_reg <= 1'b0;
                    rd_hold_reg  <= '0;
                end else begin
                    rd_valid_reg <= pop_acc;
                    if (rd_valid_reg) begin
                        rd_hold_reg <= ram_rd_data;
                    end
                end
            end
        end
    endgenerate

    // Count follows user-visible push/pop only; prefetch moves words inside.
    always_comb begin
        count_next = count_reg;
        if (push_acc && !pop_acc) begin
            count_next = count_reg + CW'(1);
        end else if (pop_acc && !push_acc) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Pointers, occupancy count and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (flush) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (fetch) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_next;
            if (wr_en && full_w) begin
                overflow_reg <= 1'b1;
            end
            if (rd_en && empty_w) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign full         = full_w;
    assign empty        = empty_w;
    assign count        = count_reg;
    assign almost_full  = (count_reg >= AFULL_C);
    assign almost_empty = (count_reg <= AEMPTY_C);
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
module tb_sync_fifo_ctrl;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int CW = AW + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // ---------------- standard-mode instance ----------------
    logic          s_flush = 0, s_wr_en = 0, s_rd_en = 0;
    logic [DW-1:0] s_wr_data = '0, s_rd_data, s_ram_wr_data;
    logic [DW-1:0] s_ram_rd_data = '0;
    logic          s_rd_valid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
    logic          s_ram_wr_en, s_ram_rd_en;
    logic [CW-1:0] s_count;
    logic [AW-1:0] s_ram_wr_addr, s_ram_rd_addr;
    logic [DW-1:0] s_mem [16];

    sync_fifo_ctrl #(.RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW), .FWFT(0),
                     .AFULL_THRESH(12), .AEMPTY_THRESH(2)) u_std (
        .clk(clk), .rst(rst), .flush(s_flush), .wr_en(s_wr_en), .wr_data(s_wr_data),
        .rd_en(s_rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full),
        .empty(s_empty), .almost_full(s_afull), .almost_empty(s_aempty), .count(s_count),
        .overflow(s_ovf), .underflow(s_udf), .ram_wr_addr(s_ram_wr_addr),
        .ram_wr_data(s_ram_wr_data), .ram_wr_en(s_ram_wr_en), .ram_rd_addr(s_ram_rd_addr),
        .ram_rd_en(s_ram_rd_en), .ram_rd_data(s_ram_rd_data));

    always @(posedge clk) begin
        if (s_ram_wr_en) s_mem[s_ram_wr_addr] <= s_ram_wr_data;
        if (s_ram_rd_en) s_ram_rd_data <= s_mem[s_ram_rd_addr];
    end

    // ---------------- FWFT instance ----------------
    logic          f_flush = 0, f_wr_en = 0, f_rd_en = 0;
    logic [DW-1:0] f_wr_data = '0, f_rd_data, f_ram_wr_data;
    logic [DW-1:0] f_ram_rd_data = '0;
    logic          f_rd_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
    logic          f_ram_wr_en, f_ram_rd_en;
    logic [CW-1:0] f_count;
    logic [AW-1:0] f_ram_wr_addr, f_ram_rd_addr;
    logic [DW-1:0] f_mem [16];

    sync_fifo_ctrl #(.RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW), .FWFT(1),
                     .AFULL_THRESH(12), .AEMPTY_THRESH(2)) u_fwft (
        .clk(clk), .rst(rst), .flush(f_flush), .wr_en(f_wr_en), .wr_data(f_wr_data),
        .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full),
        .empty(f_empty), .almost_full(f_afull), .almost_empty(f_aempty), .count(f_count),
        .overflow(f_ovf), .underflow(f_udf), .ram_wr_addr(f_ram_wr_addr),
        .ram_wr_data(f_ram_wr_data), .ram_wr_en(f_ram_wr_en), .ram_rd_addr(f_ram_rd_addr),
        .ram_rd_en(f_ram_rd_en), .ram_rd_data(f_ram_rd_data));

    always @(posedge clk) begin
        if (f_ram_wr_en) f_mem[f_ram_wr_addr] <= f_ram_wr_data;
        if (f_ram_rd_en) f_ram_rd_data <= f_mem[f_ram_rd_addr];
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_std(input string tag, input int cnt, input bit ful, input bit emp,
                           input bit ov, input bit ud);
        check({tag, "_count"}, 32'(s_count), cnt);
        check({tag, "_full"}, 32'(s_full), 32'(ful));
        check({tag, "_empty"}, 32'(s_empty), 32'(emp));
        check({tag, "_afull"}, 32'(s_afull), 32'(cnt >= 12));
        check({tag, "_aempty"}, 32'(s_aempty), 32'(cnt <= 2));
        check({tag, "_ovf"}, 32'(s_ovf), 32'(ov));
        check({tag, "_udf"}, 32'(s_udf), 32'(ud));
    endtask

    task automatic chk_fw(input string tag, input int cnt, input bit emp,
                          input bit ov, input bit ud);
        check({tag, "_count"}, 32'(f_count), cnt);
        check({tag, "_empty"}, 32'(f_empty), 32'(emp));
        check({tag, "_rd_valid"}, 32'(f_rd_valid), 32'(!emp));
        check({tag, "_afull"}, 32'(f_afull), 32'(cnt >= 12));
        check({tag, "_aempty"}, 32'(f_aempty), 32'(cnt <= 2));
        check({tag, "_ovf"}, 32'(f_ovf), 32'(ov));
        check({tag, "_udf"}, 32'(f_udf), 32'(ud));
    endtask

    typedef struct {
        logic          wr_en;
        logic          rd_en;
        logic [DW-1:0] wr_data;
        logic          exp_wen;
        logic          exp_ren;
        int            exp_cnt;
        logic          exp_full;
        logic          exp_empty;
        logic          exp_ovf;
        logic          exp_udf;
        logic          exp_rv;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t vecs [34];

    // Reference-model state for the random phase.
    logic [DW-1:0] sq[$];
    logic [DW-1:0] fq[$];

    initial begin
        logic [DW-1:0] s_last, s_popped;
        bit s_push, s_pop, f_push, f_pop, fl, s_ov, s_ud, f_ov, f_ud;
        int inval_run, wr_pct, rd_pct;

        // Fill-then-drain table: 17 pushes (last one overflows), 17 pops (last one underflows).
        for (int i = 0; i < 17; i++) begin
            vecs[i].wr_en = 1; vecs[i].rd_en = 0; vecs[i].wr_data = 16'(32'h100 + i);
            vecs[i].exp_wen = (i < 16); vecs[i].exp_ren = 0;
            vecs[i].exp_cnt = (i < 16) ? i + 1 : 16;
            vecs[i].exp_full = (vecs[i].exp_cnt == 16); vecs[i].exp_empty = 0;
            vecs[i].exp_ovf = (i == 16); vecs[i].exp_udf = 0;
            vecs[i].exp_rv = 0; vecs[i].exp_rd = '0;
        end
        for (int j = 0; j < 17; j++) begin
            vecs[17+j].wr_en = 0; vecs[17+j].rd_en = 1; vecs[17+j].wr_data = '0;
            vecs[17+j].exp_wen = 0; vecs[17+j].exp_ren = (j < 16);
            vecs[17+j].exp_cnt = (j < 16) ? 15 - j : 0;
            vecs[17+j].exp_full = 0; vecs[17+j].exp_empty = (vecs[17+j].exp_cnt == 0);
            vecs[17+j].exp_ovf = 1; vecs[17+j].exp_udf = (j == 16);
            vecs[17+j].exp_rv = (j < 16);
            vecs[17+j].exp_rd = (j < 16) ? 16'(32'h100 + j) : 16'h010F;
        end

        // Reset state, with requests asserted to show strobes stay low.
        s_wr_en = 1; s_rd_en = 1; f_wr_en = 1; f_rd_en = 1;
        repeat (2) @(posedge clk);
        #1;
        chk_std("rst_s", 0, 0, 1, 0, 0);
        check("rst_s_rd_valid", 32'(s_rd_valid), 0);
        check("rst_s_rd_data", 32'(s_rd_data), 0);
        check("rst_s_ram_wr_en", 32'(s_ram_wr_en), 0);
        check("rst_s_ram_rd_en", 32'(s_ram_rd_en), 0);
        chk_fw("rst_f", 0, 1, 0, 0);
        check("rst_f_full", 32'(f_full), 0);
        check("rst_f_rd_data", 32'(f_rd_data), 0);
        check("rst_f_ram_wr_en", 32'(f_ram_wr_en), 0);
        check("rst_f_ram_rd_en", 32'(f_ram_rd_en), 0);
        s_wr_en = 0; s_rd_en = 0; f_wr_en = 0; f_rd_en = 0;
        rst = 0;
        tick();

        // Standard mode: table-driven fill and drain.
        for (int i = 0; i < 34; i++) begin
            s_wr_en = vecs[i].wr_en; s_rd_en = vecs[i].rd_en; s_wr_data = vecs[i].wr_data;
            #1;
            check($sformatf("vec%0d_ram_wr_en", i), 32'(s_ram_wr_en), 32'(vecs[i].exp_wen));
            check($sformatf("vec%0d_ram_rd_en", i), 32'(s_ram_rd_en), 32'(vecs[i].exp_ren));
            tick();
            s_wr_en = 0; s_rd_en = 0;
            chk_std($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_full,
                    vecs[i].exp_empty, vecs[i].exp_ovf, vecs[i].exp_udf);
            check($sformatf("vec%0d_rd_valid", i), 32'(s_rd_valid), 32'(vecs[i].exp_rv));
            check($sformatf("vec%0d_rd_data", i), 32'(s_rd_data), 32'(vecs[i].exp_rd));
        end

        // Standard mode: flush clears sticky flags, then stream at count 5 across wrap.
        s_flush = 1; s_wr_en = 1; s_rd_en = 1;
        #1;
        check("s_flush_ram_wr_en", 32'(s_ram_wr_en), 0);
        check("s_flush_ram_rd_en", 32'(s_ram_rd_en), 0);
        tick();
        s_flush = 0; s_wr_en = 0; s_rd_en = 0;
        chk_std("s_flush", 0, 0, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            s_wr_en = 1; s_wr_data = 16'(32'h200 + k);
            tick();
        end
        s_wr_en = 0;
        check("s_stream_pre_count", 32'(s_count), 5);
        for (int c = 0; c < 40; c++) begin
            s_wr_en = 1; s_rd_en = 1; s_wr_data = 16'(32'h205 + c);
            tick();
            check($sformatf("s_stream%0d_count", c), 32'(s_count), 5);
            check($sformatf("s_stream%0d_rd_valid", c), 32'(s_rd_valid), 1);
            check($sformatf("s_stream%0d_rd_data", c), 32'(s_rd_data), 32'h200 + c);
        end
        s_wr_en = 0; s_rd_en = 0;

        // FWFT: single word appears two edges after its push, then pops out.
        f_wr_en = 1; f_wr_data = 16'hABCD;
        tick();
        f_wr_en = 0;
        chk_fw("t4_n0", 1, 1, 0, 0);
        tick();
        chk_fw("t4_n1", 1, 1, 0, 0);
        tick();
        chk_fw("t4_n2", 1, 0, 0, 0);
        check("t4_rd_data", 32'(f_rd_data), 32'hABCD);
        f_rd_en = 1;
        tick();
        f_rd_en = 0;
        chk_fw("t4_pop", 0, 1, 0, 0);

        // FWFT: 18 words (16 in RAM + 2 staged), then drain with no bubbles.
        for (int k = 0; k < 18; k++) begin
            f_wr_en = 1; f_wr_data = 16'(32'h400 + k);
            #1;
            check($sformatf("t5_push%0d_ram_wr_en", k), 32'(f_ram_wr_en), 1);
            tick();
        end
        f_wr_en = 0;
        check("t5_full", 32'(f_full), 1);
        chk_fw("t5_loaded", 18, 0, 0, 0);
        repeat (3) tick();
        for (int k = 0; k < 18; k++) begin
            f_rd_en = 1;
            #1;
            check($sformatf("t5_pop%0d_rd_valid", k), 32'(f_rd_valid), 1);
            check($sformatf("t5_pop%0d_rd_data", k), 32'(f_rd_data), 32'h400 + k);
            tick();
        end
        f_rd_en = 0;
        chk_fw("t5_drained", 0, 1, 0, 0);

        // FWFT: flush with a RAM read in flight and a pop requested.
        f_rd_en = 1;
        tick();
        f_rd_en = 0;
        chk_fw("t6_udf", 0, 1, 0, 1);
        for (int k = 0; k < 10; k++) begin
            f_wr_en = 1; f_wr_data = 16'(32'h300 + k);
            tick();
        end
        f_wr_en = 0;
        repeat (3) tick();
        check("t6_head", 32'(f_rd_data), 32'h300);
        f_rd_en = 1;
        #1;
        check("t6_prefetch", 32'(f_ram_rd_en), 1);
        tick();
        chk_fw("t6_pre_flush", 9, 0, 0, 1);
        f_flush = 1; f_wr_en = 1; f_wr_data = 16'hDEAD;
        #1;
        check("t6_flush_ram_wr_en", 32'(f_ram_wr_en), 0);
        check("t6_flush_ram_rd_en", 32'(f_ram_rd_en), 0);
        tick();
        f_flush = 0; f_wr_en = 0; f_rd_en = 0;
        chk_fw("t6_flushed", 0, 1, 0, 0);
        check("t6_flushed_rd_data", 32'(f_rd_data), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_fw($sformatf("t6_idle%0d", k), 0, 1, 0, 0);
        end
        f_wr_en = 1; f_wr_data = 16'h0055;
        tick();
        f_wr_en = 0;
        repeat (2) tick();
        chk_fw("t6_fresh", 1, 0, 0, 0);
        check("t6_fresh_rd_data", 32'(f_rd_data), 32'h55);

        // Randomized phase on both instances against queue models.
        s_flush = 1; f_flush = 1;
        tick();
        s_flush = 0; f_flush = 0;
        sq.delete(); fq.delete();
        s_last = '0; s_ov = 0; s_ud = 0; f_ov = 0; f_ud = 0; inval_run = 0;
        for (int c = 0; c < 1200; c++) begin
            case ((c / 150) % 4)
                0: begin wr_pct = 75; rd_pct = 25; end
                1: begin wr_pct = 25; rd_pct = 80; end
                2: begin wr_pct = 90; rd_pct = 55; end
                default: begin wr_pct = 50; rd_pct = 95; end
            endcase
            fl = ($urandom_range(0, 299) == 0);
            s_flush = fl; f_flush = fl;
            s_wr_en = ($urandom_range(0, 99) < wr_pct); s_rd_en = ($urandom_range(0, 99) < rd_pct);
            f_wr_en = ($urandom_range(0, 99) < wr_pct); f_rd_en = ($urandom_range(0, 99) < rd_pct);
            s_wr_data = 16'($urandom); f_wr_data = 16'($urandom);
            #1;
            s_push = !fl && s_wr_en && (sq.size() < 16);
            s_pop  = !fl && s_rd_en && (sq.size() > 0);
            f_push = !fl && f_wr_en && !f_full;
            f_pop  = !fl && f_rd_en && f_rd_valid;
            check("r_s_ram_wr_en", 32'(s_ram_wr_en), 32'(s_push));
            check("r_s_ram_rd_en", 32'(s_ram_rd_en), 32'(s_pop));
            check("r_f_ram_wr_en", 32'(f_ram_wr_en), 32'(f_push));
            if (f_pop) check("r_f_rd_data", 32'(f_rd_data), 32'(fq[0]));
            if (!fl) begin
                if (s_wr_en && sq.size() == 16) s_ov = 1;
                if (s_rd_en && sq.size() == 0) s_ud = 1;
                if (f_wr_en && f_full) f_ov = 1;
                if (f_rd_en && !f_rd_valid) f_ud = 1;
            end
            tick();
            if (fl) begin
                sq.delete(); fq.delete();
                s_last = '0; s_ov = 0; s_ud = 0; f_ov = 0; f_ud = 0;
            end else begin
                if (s_pop) begin s_popped = sq.pop_front(); s_last = s_popped; end
                if (s_push) sq.push_back(s_wr_data);
                if (f_pop) void'(fq.pop_front());
                if (f_push) fq.push_back(f_wr_data);
            end
            chk_std("r_s", sq.size(), sq.size() == 16, sq.size() == 0, s_ov, s_ud);
            check("r_s_rd_valid", 32'(s_rd_valid), 32'(s_pop));
            check("r_s_rd_data", 32'(s_rd_data), 32'(s_last));
            check("r_f_count", 32'(f_count), fq.size());
            check("r_f_afull", 32'(f_afull), 32'(fq.size() >= 12));
            check("r_f_aempty", 32'(f_aempty), 32'(fq.size() <= 2));
            check("r_f_ovf", 32'(f_ovf), 32'(f_ov));
            check("r_f_udf", 32'(f_udf), 32'(f_ud));
            check("r_f_valid_nonempty", 32'(f_rd_valid && fq.size() == 0), 0);
            if (fq.size() < 16) check("r_f_full_early", 32'(f_full), 0);
            if (fq.size() == 18) check("r_f_full_max", 32'(f_full), 1);
            inval_run = (fq.size() > 0 && !f_rd_valid) ? inval_run + 1 : 0;
            check("r_f_head_latency", 32'(inval_run > 2), 0);
        end
        s_flush = 0; f_flush = 0; s_wr_en = 0; s_rd_en = 0; f_wr_en = 0; f_rd_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
